// File: rtl/fifo_word_packer.sv
// Packs BYTES_PER_WORD show-ahead FIFO bytes (LSB first) into one word on a valid/ready port.
// Optional partial-word flush after an idle timeout: define FIFO_WORD_PACKER_TIMEOUT_EN.
module fifo_word_packer #(
  parameter int BYTE_WIDTH     = 8,
  parameter int BYTES_PER_WORD = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [BYTE_WIDTH-1:0]                fifo_data_out,
  input  logic                                 fifo_data_out_vld,
  output logic                                 fifo_data_pop,
  output logic [BYTE_WIDTH*BYTES_PER_WORD-1:0] word_out,
  output logic                                 word_out_vld,
  input  logic                                 word_out_rdy,
  output logic [$clog2(BYTES_PER_WORD):0]      word_out_nbytes
);

  localparam int CW = $clog2(BYTES_PER_WORD) + 1;
  localparam int IW = $clog2(BYTES_PER_WORD);

  typedef enum logic {FILL, HOLD} state_t;

  state_t                                   state, state_nxt;
  logic [CW-1:0]                            byte_cnt;
  logic [BYTES_PER_WORD-1:0][BYTE_WIDTH-1:0] word_q;
  logic                                     last_slot;
  logic                                     handshake;
  logic                                     flush;

  assign last_slot = (byte_cnt == CW'(BYTES_PER_WORD - 1));
  assign handshake = (state == HOLD) & word_out_rdy;

`ifdef FIFO_WORD_PACKER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_cnt;

  // Saturates at TIMEOUT_CYCLES; a pop on the flush edge takes priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      idle_cnt <= '0;
    else if (state == HOLD || fifo_data_pop || byte_cnt == '0)
      idle_cnt <= '0;
    else if (!fifo_data_out_vld && idle_cnt != TW'(TIMEOUT_CYCLES))
      idle_cnt <= idle_cnt + 1'b1;
  end

  assign flush = (state == FILL) & (byte_cnt != '0) & ~fifo_data_pop &
                 (idle_cnt == TW'(TIMEOUT_CYCLES));
`else
  assign flush = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= FILL;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL: if ((fifo_data_pop & last_slot) | flush) state_nxt = HOLD;
      HOLD: if (word_out_rdy) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_comb begin
    fifo_data_pop   = reset_n & fifo_data_out_vld & ((state == FILL) | word_out_rdy);
    word_out_vld    = (state == HOLD);
    word_out_nbytes = (state == HOLD) ? byte_cnt : '0;
    word_out        = word_q;
  end

  // A handshake retires the word; a same-cycle pop seeds slot 0 of a fresh word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_q   <= '0;
      byte_cnt <= '0;
    end else if (handshake) begin
      word_q <= '0;
      if (fifo_data_pop) begin
        word_q[0] <= fifo_data_out;
        byte_cnt  <= CW'(1);
      end else begin
        byte_cnt  <= '0;
      end
    end else if (fifo_data_pop) begin
      word_q[byte_cnt[IW-1:0]] <= fifo_data_out;
      byte_cnt                 <= byte_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Self-checking bench for fifo_word_packer: FIFO model feeds bytes, scoreboard checks packed words.
module tb_fifo_word_packer;

  localparam int BW  = 8;
  localparam int BPW = 4;
  localparam int TO  = 5;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [BW-1:0] fifo_data_out;
  logic          fifo_data_out_vld;
  logic          fifo_data_pop;
  logic [31:0]   word_out;
  logic          word_out_vld;
  logic          word_out_rdy;
  logic [2:0]    word_out_nbytes;

  fifo_word_packer #(.BYTE_WIDTH(BW), .BYTES_PER_WORD(BPW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .fifo_data_out(fifo_data_out), .fifo_data_out_vld(fifo_data_out_vld),
    .fifo_data_pop(fifo_data_pop),
    .word_out(word_out), .word_out_vld(word_out_vld), .word_out_rdy(word_out_rdy),
    .word_out_nbytes(word_out_nbytes)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] w; int n; } exp_t;

  exp_t        sb[$];
  logic [7:0]  fq[$];
  logic [31:0] m_word = '0;
  int          m_n = 0;
  int          n_tests = 0, n_fail = 0;
  int          pop_cnt = 0, hs_cnt = 0, vld_seen = 0;
  bit          p_seen;
  bit          prev_hold = 1'b0;
  logic [31:0] prev_word;
  logic [2:0]  prev_nb;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fifo_sync();
    fifo_data_out_vld = (fq.size() > 0);
    fifo_data_out     = (fq.size() > 0) ? fq[0] : 8'h00;
  endtask

  // Byte that the packer is expected to deliver; scoreboard gets a word every BPW bytes.
  task automatic push_byte(input logic [7:0] b);
    fq.push_back(b);
    fifo_sync();
    m_word[8*m_n +: 8] = b;
    m_n++;
    if (m_n == BPW) begin
      sb.push_back('{m_word, BPW});
      m_word = '0;
      m_n    = 0;
    end
  endtask

  task automatic push_raw(input logic [7:0] b);
    fq.push_back(b);
    fifo_sync();
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Returns the number of negedges until word_out_vld is seen, or -1 when the bound runs out.
  task automatic wait_vld(input int max, output int n);
    n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (word_out_vld) break;
      if (n >= max) begin n = -1; break; end
    end
  endtask

  // FIFO model: the pop seen at the edge removes the head just after it.
  always @(posedge clk) begin
    p_seen = fifo_data_pop;
    #1;
    if (p_seen && fq.size() > 0) begin
      void'(fq.pop_front());
      pop_cnt++;
      fifo_sync();
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (!word_out_vld) chk("nbytes_idle", 64'(word_out_nbytes), 64'd0);
      if (!fifo_data_out_vld) chk("pop_empty", 64'(fifo_data_pop), 64'd0);
      if (prev_hold) begin
        chk("hold_word", 64'(word_out), 64'(prev_word));
        chk("hold_nbytes", 64'(word_out_nbytes), 64'(prev_nb));
      end
      if (word_out_vld) vld_seen++;
      if (word_out_vld && word_out_rdy) begin
        hs_cnt++;
        if (sb.size() == 0) chk("sb_underflow", 64'(sb.size()), 64'd1);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("word", 64'(word_out), 64'(e.w));
          chk("nbytes", 64'(word_out_nbytes), 64'(e.n));
        end
      end
      prev_hold = word_out_vld && !word_out_rdy;
      prev_word = word_out;
      prev_nb   = word_out_nbytes;
    end else begin
      prev_hold = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, base_pop, base_hs, base_vld, gap;
    reset_n      = 1'b0;
    word_out_rdy = 1'b1;
    fifo_sync();

    // Reset state, with a byte offered to show pop stays low.
    push_raw(8'h99);
    #7;
    chk("rst_vld", 64'(word_out_vld), 64'd0);
    chk("rst_word", 64'(word_out), 64'd0);
    chk("rst_nbytes", 64'(word_out_nbytes), 64'd0);
    chk("rst_pop", 64'(fifo_data_pop), 64'd0);
    fq.delete();
    fifo_sync();
    tick();
    reset_n = 1'b1;
    tick();

    // Single word, latency and one-cycle valid.
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
    wait_vld(20, n);
    chk("t1_latency", 64'(n), 64'd5);
    chk("t1_word", 64'(word_out), 64'h44332211);
    @(negedge clk);
    chk("t1_vld_1cyc", 64'(word_out_vld), 64'd0);
    tick();

    // Two back-to-back words: 8 pops in 8 cycles, valid in 2 cycles.
    base_pop = pop_cnt; base_hs = hs_cnt; base_vld = vld_seen;
    for (int i = 1; i <= 8; i++) push_byte(8'(i));
    repeat (8) tick();
    chk("t2_pops", 64'(pop_cnt - base_pop), 64'd8);
    repeat (3) tick();
    chk("t2_words", 64'(hs_cnt - base_hs), 64'd2);
    chk("t2_vld_cycles", 64'(vld_seen - base_vld), 64'd2);

    // Backpressure with a non-empty FIFO, then pop and handshake on one edge.
    word_out_rdy = 1'b0;
    push_byte(8'hA1); push_byte(8'hA2); push_byte(8'hA3); push_byte(8'hA4);
    push_byte(8'h55); push_byte(8'h66); push_byte(8'h77); push_byte(8'h88);
    wait_vld(20, n);
    chk("t3_full", 64'(n > 0), 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t3_bp_pop", 64'(fifo_data_pop), 64'd0);
      chk("t3_bp_word", 64'(word_out), 64'hA4A3A2A1);
    end
    tick();
    word_out_rdy = 1'b1;
    @(negedge clk);
    wait_vld(20, n);
    chk("t3_no_bubble", 64'(n), 64'd4);
    chk("t3_word2", 64'(word_out), 64'h88776655);
    repeat (2) tick();

    // Asynchronous reset mid-word discards partial bytes.
    push_raw(8'hAA); push_raw(8'hBB);
    repeat (3) tick();
    #1;
    reset_n = 1'b0;
    #1;
    push_raw(8'h99);
    #1;
    chk("t4_rst_vld", 64'(word_out_vld), 64'd0);
    chk("t4_rst_word", 64'(word_out), 64'd0);
    chk("t4_rst_pop", 64'(fifo_data_pop), 64'd0);
    fq.delete();
    fifo_sync();
    #3;
    reset_n = 1'b1;
    tick();
    push_byte(8'h01); push_byte(8'h02); push_byte(8'h03); push_byte(8'h04);
    wait_vld(20, n);
    chk("t4_word", 64'(word_out), 64'h04030201);
    repeat (2) tick();

    // Partial word followed by an idle FIFO.
    base_vld = vld_seen;
    push_byte(8'hC1); push_byte(8'hC2);
`ifdef FIFO_WORD_PACKER_TIMEOUT_EN
    sb.push_back('{32'h0000C2C1, 2});
    m_word = '0; m_n = 0;
    wait_vld(30, n);
    chk("t5_flush_seen", 64'(n > 0), 64'd1);
    chk("t5_flush_word", 64'(word_out), 64'h0000C2C1);
    chk("t5_flush_nbytes", 64'(word_out_nbytes), 64'd2);
    repeat (2) tick();
`else
    repeat (30) tick();
    chk("t5_no_flush", 64'(vld_seen - base_vld), 64'd0);
    reset_n = 1'b0;
    m_word = '0; m_n = 0;
    tick();
    reset_n = 1'b1;
    tick();
`endif

    // Random traffic with random backpressure; gaps stay below the timeout.
    gap = 0;
    for (int i = 0; i < 240; ) begin
      word_out_rdy = ($urandom_range(0, 9) < 7);
      if (gap >= 2 || $urandom_range(0, 2) != 0) begin
        push_byte(8'($urandom));
        i++;
        gap = 0;
      end else begin
        gap++;
      end
      tick();
    end
    word_out_rdy = 1'b1;
    for (int k = 0; k < 600 && (sb.size() > 0 || fq.size() > 0); k++) tick();
    repeat (2) tick();
    chk("sb_left", 64'(sb.size()), 64'd0);
    chk("fifo_left", 64'(fq.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_word_packer.md
Name: fifo_word_packer

Overview:
- Sits directly downstream of the byte-wide generic FIFO. Pops bytes from the FIFO's show-ahead output and packs BYTES_PER_WORD bytes, least significant byte first, into one wide word.
- Presents the word on a valid/ready interface to the accelerator's word-level datapath.
- The FIFO side needs no handshake beyond pop; the word side uses standard valid/ready backpressure.

Parameters:
- BYTE_WIDTH, 8, width of one FIFO entry.
- BYTES_PER_WORD, 4, bytes per output word; must be ≥2.
- TIMEOUT_CYCLES, 255, idle cycles before a partial word is flushed; used only with the optional feature; must be ≥1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- fifo_data_out  in  BYTE_WIDTH  head byte from FIFO; valid whenever fifo_data_out_vld=1.
- fifo_data_out_vld  in  1  FIFO not empty.
- fifo_data_pop  out  1  consume head byte this cycle.
- word_out  out  BYTE_WIDTH*BYTES_PER_WORD  packed word; byte 0 in [BYTE_WIDTH-1:0].
- word_out_vld  out  1  word_out holds a complete (or flushed) word.
- word_out_rdy  in  1  downstream accepts word_out.
- word_out_nbytes  out  $clog2(BYTES_PER_WORD)+1  count of valid bytes in word_out.

Behaviour:
- Reset: the one clock is clk; reset_n is asynchronous, active-low. Reset asserted, including mid-word, forces:
  - state=FILL, byte_cnt=0, word register=0
  - word_out_vld=0, word_out=0, word_out_nbytes=0, fifo_data_pop=0
  - any partial bytes are discarded.
- States: FILL (collecting bytes) and HOLD (word presented, waiting for word_out_rdy).
- Pop rule (combinational): fifo_data_pop = fifo_data_out_vld & (state==FILL | word_out_rdy). Never asserted when fifo_data_out_vld=0.
- Capture: on each edge with fifo_data_pop=1:
  - fifo_data_out is written into byte slot byte_cnt; byte_cnt increments.
  - Slots above byte_cnt keep 0; the word register is cleared when a new word starts.
- FILL→HOLD: on the edge that captures slot BYTES_PER_WORD-1. word_out_vld=1 and word_out_nbytes=BYTES_PER_WORD from the next cycle. Latency from last byte pop to word_out_vld is 1 cycle.
- HOLD:
  - word_out and word_out_nbytes stay stable while word_out_vld=1 and word_out_rdy=0.
  - No pops occur in HOLD without word_out_rdy.
- HOLD handshake (word_out_vld & word_out_rdy on an edge):
  - If no pop that cycle: go to FILL, byte_cnt=0, word_out_vld=0.
  - If pop that cycle: the new byte goes to slot 0 of a cleared word, byte_cnt=1, state=FILL. This gives no bubble, so sustained throughput is 1 byte/cycle.
  - If BYTES_PER_WORD bytes arrive back-to-back and rdy is held high, word_out_vld is high 1 cycle out of every BYTES_PER_WORD.
- byte_cnt wraps to 0 only through the HOLD handshake; it never exceeds BYTES_PER_WORD.
- word_out_nbytes is 0 whenever word_out_vld=0.
- No combinational path from word_out_rdy to word_out_vld. fifo_data_pop does depend combinationally on word_out_rdy and fifo_data_out_vld.

Optional Feature:
- Macro: FIFO_WORD_PACKER_TIMEOUT_EN.
- Defined:
  - An idle counter counts consecutive FILL cycles with byte_cnt>0 and fifo_data_out_vld=0. It clears on any pop, in HOLD, and at reset.
  - When it reaches TIMEOUT_CYCLES, the next edge moves to HOLD with the partial word: unfilled slots are 0 and word_out_nbytes=byte_cnt.
  - A pop arriving on the same edge as the timeout wins: the byte is captured and the counter clears.
  - An empty word (byte_cnt=0) never times out.
- Not defined: no counter is built; partial words wait indefinitely; word_out_nbytes is always BYTES_PER_WORD while valid.

Test Plan:
- Reset then FIFO supplies 0x11,0x22,0x33,0x44 back-to-back, rdy=1 -> word_out=0x44332211 with nbytes=4, vld for exactly 1 cycle, 1 cycle after the 4th pop.
- 8 bytes 0x01..0x08 continuous, rdy=1 -> words 0x04030201 then 0x08070605, with 4 pops per 4 cycles and no stall cycle.
- Complete word, rdy=0 for 10 cycles with FIFO non-empty -> fifo_data_pop=0, word_out stable for all 10 cycles. Raise rdy -> pop and handshake on the same edge; the next word starts with byte_cnt=1.
- reset_n pulsed low asynchronously after 2 bytes (0xAA,0xBB), then 0x01..0x04 supplied -> outputs 0 during reset; first word 0x04030201; 0xAA/0xBB never appear.
- TIMEOUT_EN, TIMEOUT_CYCLES=5: bytes 0xC1,0xC2, then FIFO empty -> after 5 idle cycles, word_out=0x0000C2C1, nbytes=2, vld=1.
- TIMEOUT_EN: byte arrives on the 5th idle cycle -> no flush, byte_cnt=3. Without the macro, the same stimulus never asserts vld.
